// File: rtl/he_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | he_pkg                                                               |
// | Hamming layout helpers shared by the stream encoder and the decoder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package he_pkg;

  // Positions are 1-based codeword indices; parity bits live at powers of two.
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int he_min_parity(input int k);
    int m;
    m = 0;
    for (int i = 1; i < 31; i++) begin
      if (m == 0 && (1 << i) >= k + i + 1) m = i;
    end
    return m;
  endfunction

  // Number of data positions strictly below pos, i.e. the data index held at pos.
  function automatic int he_data_rank(input int pos);
    int cnt;
    cnt = 0;
    for (int p = 1; p < 4096; p++) begin
      if (p < pos && !is_pow2(p)) cnt++;
    end
    return cnt;
  endfunction

  function automatic int he_data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 4096; p++) begin
      if (pos == 0 && !is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/he_secded_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | he_secded_stream_if                                                  |
// | Data-in and codeword-out valid/ready streams of the encoder.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface he_secded_stream_if #(
  parameter int K = 7,
  parameter int N = 11
);
  logic [K-1:0] din;
  logic         dvld;
  logic         drdy;
  logic [N-1:0] cout;
  logic         cvld;
  logic         crdy;

  modport master (output din, dvld, crdy, input drdy, cout, cvld);
  modport slave  (input din, dvld, crdy, output drdy, cout, cvld);
endinterface
`default_nettype wire

// File: rtl/he_secded_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | he_secded_core                                                       |
// | Combinational Hamming / SECDED encoder: data word -> codeword.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module he_secded_core
  import he_pkg::*;
#(
  parameter int K   = 7,
  parameter int M   = 4,
  parameter int EXT = 0
) (
  input  logic [K-1:0]       din,
  output logic [K+M+EXT-1:0] code
);
  localparam int NH = K + M;

  logic [NH-1:0] w_dcw;
  logic [NH-1:0] w_ham;
  logic [NH-1:0] w_cov [M];

  // Data-only word: parity slots (and any surplus slots) read as zero.
  for (genvar p = 0; p < NH; p++) begin : g_pos
    if (is_pow2(p + 1)) begin : g_par
      assign w_dcw[p] = 1'b0;
    end else if (he_data_rank(p + 1) < K) begin : g_dat
      assign w_dcw[p] = din[he_data_rank(p + 1)];
    end else begin : g_pad
      assign w_dcw[p] = 1'b0;
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_cov
    for (genvar p = 0; p < NH; p++) begin : g_bit
      if ((((p + 1) >> j) & 1) == 1) begin : g_in
        assign w_cov[j][p] = w_dcw[p];
      end else begin : g_out
        assign w_cov[j][p] = 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NH; p++) begin : g_ham
    if (is_pow2(p + 1)) begin : g_par
      assign w_ham[p] = ^w_cov[$clog2(p + 1)];
    end else begin : g_dat
      assign w_ham[p] = w_dcw[p];
    end
  end

  if (EXT != 0) begin : g_ext
    assign code = {^w_ham, w_ham};
  end else begin : g_noext
    assign code = w_ham;
  end
endmodule
`default_nettype wire

// File: rtl/he_secded_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | he_secded_stream                                                     |
// | Two-stage valid/ready Hamming encoder with bit injection and counter.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module he_secded_stream
  import he_pkg::*;
#(
  parameter int K   = 7,
  parameter int M   = 4,
  parameter int EXT = 0,
  parameter int CW  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  he_secded_stream_if.slave             bus,
  input  logic                          inj_en,
  input  logic [$clog2(K+M+EXT)-1:0]    inj_pos,
  output logic [CW-1:0]                 wcnt
);
  localparam int N  = K + M + EXT;
  localparam int PW = $clog2(N);
  localparam logic [PW:0]  c_n   = (PW + 1)'(N);
  localparam logic [N-1:0] c_one = N'(1);

  if (M < he_min_parity(K)) begin : g_bad_m
    $error("he_secded_stream: M too small for K data bits");
  end

  logic          r_s1_vld;
  logic [K-1:0]  r_s1_data;
  logic          r_cvld;
  logic [N-1:0]  r_cout;
  logic [CW-1:0] r_wcnt;

  logic          w_s2_rdy;
  logic          w_s1_rdy;
  logic          w_in_hs;
  logic          w_adv;
  logic          w_out_hs;
  logic [N-1:0]  w_code;
  logic [N-1:0]  w_flip;

  he_secded_core #(.K(K), .M(M), .EXT(EXT)) u_core (
    .din  (r_s1_data),
    .code (w_code)
  );

  assign w_s2_rdy = !r_cvld || bus.crdy;
  assign w_s1_rdy = !r_s1_vld || w_s2_rdy;
  assign w_in_hs  = bus.dvld && w_s1_rdy;
  assign w_adv    = r_s1_vld && w_s2_rdy;
  assign w_out_hs = r_cvld && bus.crdy;

  // Flip is applied after parity so the decoder sees a genuine channel error.
  assign w_flip = (inj_en && ({1'b0, inj_pos} < c_n)) ? (c_one << inj_pos) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_cvld    <= 1'b0;
      r_cout    <= '0;
      r_wcnt    <= '0;
    end else begin
      if (w_s1_rdy) begin
        r_s1_vld <= bus.dvld;
        if (w_in_hs) r_s1_data <= bus.din;
      end
      if (w_s2_rdy) begin
        r_cvld <= r_s1_vld;
        if (w_adv) r_cout <= w_code ^ w_flip;
      end
      if (w_out_hs) r_wcnt <= r_wcnt + CW'(1);
    end
  end

  assign bus.drdy = w_s1_rdy;
  assign bus.cout = r_cout;
  assign bus.cvld = r_cvld;
  assign wcnt     = r_wcnt;
endmodule
`default_nettype wire

// File: tb/tb_he_secded_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_he_secded_stream                                                  |
// | Directed + random bench for three encoder configurations.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_he_secded_stream;
  logic tst_clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  initial tst_clk = 1'b0;
  always #5 tst_clk = ~tst_clk;

  he_secded_stream_if #(.K(4), .N(7))  ba ();
  he_secded_stream_if #(.K(4), .N(8))  bb ();
  he_secded_stream_if #(.K(7), .N(11)) bc ();

  logic       a_inj_en, b_inj_en, c_inj_en;
  logic [2:0] a_inj_pos, b_inj_pos;
  logic [3:0] c_inj_pos;
  logic [2:0]  a_wcnt;
  logic [15:0] b_wcnt, c_wcnt;

  he_secded_stream #(.K(4), .M(3), .EXT(0), .CW(3)) u_a (
    .clk(tst_clk), .rst(rst), .bus(ba), .inj_en(a_inj_en), .inj_pos(a_inj_pos), .wcnt(a_wcnt));
  he_secded_stream #(.K(4), .M(3), .EXT(1), .CW(16)) u_b (
    .clk(tst_clk), .rst(rst), .bus(bb), .inj_en(b_inj_en), .inj_pos(b_inj_pos), .wcnt(b_wcnt));
  he_secded_stream u_c (
    .clk(tst_clk), .rst(rst), .bus(bc), .inj_en(c_inj_en), .inj_pos(c_inj_pos), .wcnt(c_wcnt));

  // Reference: data bits fill non-power-of-two slots; parity bits are the XOR of
  // the positions of all set data bits, which makes the full syndrome zero.
  function automatic logic [31:0] ref_encode(input int k, input int m, input int ext,
                                             input logic [31:0] d);
    logic [31:0] code;
    int syn;
    int di;
    code = '0;
    syn  = 0;
    di   = 0;
    for (int pos = 1; pos <= k + m; pos++) begin
      if ((pos & (pos - 1)) != 0 && di < k) begin
        if (d[di]) begin
          code[pos-1] = 1'b1;
          syn = syn ^ pos;
        end
        di++;
      end
    end
    for (int j = 0; j < m; j++) begin
      if ((1 << j) <= k + m) code[(1 << j) - 1] = syn[j];
    end
    if (ext != 0) code[k+m] = ^code;
    return code;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tst_clk);
    #1;
  endtask

  logic [31:0] q_c[$];
  int c_run, c_maxrun, c_nout, c_nacc, c_spurious;
  logic c_hold_vld;
  logic [10:0] c_hold;

  // One cycle on DUT C: drive after the edge, observe at the falling edge.
  task automatic cyc_c(input logic v, input logic [6:0] d, input logic r);
    @(posedge tst_clk);
    #1;
    bc.dvld = v;
    bc.din  = d;
    bc.crdy = r;
    @(negedge tst_clk);
    if (bc.cvld) begin
      c_run++;
      if (c_run > c_maxrun) c_maxrun = c_run;
    end else begin
      c_run = 0;
    end
    if (!bc.crdy && c_hold_vld) begin
      check("c_stall_cvld", {31'd0, bc.cvld}, 32'd1);
      check("c_stall_cout", {21'd0, bc.cout}, {21'd0, c_hold});
    end
    c_hold_vld = bc.cvld && !bc.crdy;
    c_hold     = bc.cout;
    if (bc.cvld && bc.crdy) begin
      c_nout++;
      if (q_c.size() > 0) check("c_stream_word", {21'd0, bc.cout}, q_c.pop_front());
      else c_spurious++;
    end
    if (bc.dvld && bc.drdy) begin
      c_nacc++;
      q_c.push_back(ref_encode(7, 4, 0, {25'd0, d}));
    end
  endtask

  initial begin
    rst = 1'b0;
    ba.din = '0; ba.dvld = 1'b0; ba.crdy = 1'b1;
    bb.din = '0; bb.dvld = 1'b0; bb.crdy = 1'b1;
    bc.din = '0; bc.dvld = 1'b0; bc.crdy = 1'b1;
    a_inj_en = 1'b0; a_inj_pos = '0;
    b_inj_en = 1'b0; b_inj_pos = '0;
    c_inj_en = 1'b0; c_inj_pos = '0;
    c_run = 0; c_maxrun = 0; c_nout = 0; c_nacc = 0; c_spurious = 0;
    c_hold_vld = 1'b0; c_hold = '0;

    repeat (2) tick();
    check("rst_a_cvld", {31'd0, ba.cvld}, 32'd0);
    check("rst_a_cout", {25'd0, ba.cout}, 32'd0);
    check("rst_a_wcnt", {29'd0, a_wcnt}, 32'd0);
    check("rst_c_cvld", {31'd0, bc.cvld}, 32'd0);
    rst = 1'b1;
    #1;
    check("a_drdy_after_rst", {31'd0, ba.drdy}, 32'd1);

    // Single word on K=4 plain Hamming: two-cycle latency.
    tick();
    ba.din = 4'b1011; ba.dvld = 1'b1;
    tick();
    ba.dvld = 1'b0;
    check("a_lat_cvld_t1", {31'd0, ba.cvld}, 32'd0);
    tick();
    check("a_lat_cvld_t2", {31'd0, ba.cvld}, 32'd1);
    check("a_cout_1011", {25'd0, ba.cout}, 32'h55);
    check("a_cout_ref", {25'd0, ba.cout}, ref_encode(4, 3, 0, 32'hB));
    tick();
    check("a_wcnt_1", {29'd0, a_wcnt}, 32'd1);
    check("a_cvld_drained", {31'd0, ba.cvld}, 32'd0);

    // Injection inside range, then out of range.
    ba.dvld = 1'b1; a_inj_en = 1'b1; a_inj_pos = 3'd2;
    tick();
    ba.dvld = 1'b0;
    tick();
    check("a_inj_pos2", {25'd0, ba.cout}, 32'h51);
    a_inj_pos = 3'd7; ba.dvld = 1'b1;
    tick();
    ba.dvld = 1'b0;
    tick();
    check("a_inj_pos7", {25'd0, ba.cout}, 32'h55);
    tick();

    // A word parked in stage 2 is immune to injection.
    a_inj_en = 1'b0; ba.crdy = 1'b0; ba.dvld = 1'b1;
    tick();
    ba.dvld = 1'b0;
    tick();
    a_inj_en = 1'b1; a_inj_pos = 3'd0;
    tick();
    tick();
    check("a_s2_immune_cvld", {31'd0, ba.cvld}, 32'd1);
    check("a_s2_immune_cout", {25'd0, ba.cout}, 32'h55);
    a_inj_en = 1'b0; ba.crdy = 1'b1;
    tick();

    // Counter wrap with CW=3: 4 words so far plus 6 more.
    ba.dvld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ba.din = 4'($urandom);
      tick();
    end
    ba.dvld = 1'b0;
    repeat (3) tick();
    check("a_wcnt_wrap", {29'd0, a_wcnt}, 32'd2);

    // SECDED variant.
    bb.din = 4'b1011; bb.dvld = 1'b1;
    tick();
    bb.dvld = 1'b0;
    tick();
    check("b_cout_1011", {24'd0, bb.cout}, 32'h55);
    check("b_ovp_1011", {31'd0, bb.cout[7]}, 32'd0);
    tick();
    bb.din = 4'b0001; bb.dvld = 1'b1;
    tick();
    bb.dvld = 1'b0;
    tick();
    check("b_cout_0001", {24'd0, bb.cout}, 32'h87);
    check("b_ovp_0001", {31'd0, bb.cout[7]}, 32'd1);
    check("b_cout_ref", {24'd0, bb.cout}, ref_encode(4, 3, 1, 32'h1));
    tick();
    check("b_wcnt", {16'd0, b_wcnt}, 32'd2);

    // Defaults: 16-word back-to-back stream.
    c_run = 0; c_maxrun = 0;
    for (int i = 0; i < 16; i++) cyc_c(1'b1, 7'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) cyc_c(1'b0, 7'd0, 1'b1);
    check("c_stream_nout", c_nout, 32'd16);
    check("c_stream_run", c_maxrun, 32'd16);
    check("c_stream_wcnt", {16'd0, c_wcnt}, 32'd16);

    // Downstream stall for 5 cycles under a continuous stream.
    c_nacc = 0;
    for (int i = 0; i < 5; i++) cyc_c(1'b1, 7'($urandom), 1'b0);
    check("c_stall_accepts", c_nacc, 32'd2);
    check("c_stall_drdy", {31'd0, bc.drdy}, 32'd0);
    for (int i = 0; i < 6; i++) cyc_c(1'b1, 7'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) cyc_c(1'b0, 7'd0, 1'b1);
    check("c_stall_drained", q_c.size(), 32'd0);
    check("c_spurious", c_spurious, 32'd0);
    check("c_total_wcnt", {16'd0, c_wcnt}, 32'(16 + c_nacc));

    // Asynchronous reset with two words in flight on DUT A.
    ba.crdy = 1'b0; ba.dvld = 1'b1; ba.din = 4'($urandom);
    tick();
    ba.din = 4'($urandom);
    tick();
    ba.dvld = 1'b0;
    check("a_pre_rst_cvld", {31'd0, ba.cvld}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("a_async_cvld", {31'd0, ba.cvld}, 32'd0);
    check("a_async_cout", {25'd0, ba.cout}, 32'd0);
    check("a_async_wcnt", {29'd0, a_wcnt}, 32'd0);
    check("c_async_wcnt", {16'd0, c_wcnt}, 32'd0);
    ba.din = 4'b1111; ba.dvld = 1'b1;
    tick();
    tick();
    rst = 1'b1; ba.dvld = 1'b0; ba.crdy = 1'b1;
    tick();
    tick();
    check("a_no_stale_cvld", {31'd0, ba.cvld}, 32'd0);
    ba.din = 4'b0001; ba.dvld = 1'b1;
    tick();
    ba.dvld = 1'b0;
    check("a_post_rst_t1", {31'd0, ba.cvld}, 32'd0);
    tick();
    check("a_post_rst_cvld", {31'd0, ba.cvld}, 32'd1);
    check("a_post_rst_cout", {25'd0, ba.cout}, ref_encode(4, 3, 0, 32'h1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
